pipeline: RTL and testbench

PIPELINE -- requirements
Module: pipeline

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/pipe_stage_reg.sv | 28 ++
 rtl/pipeline.sv | 81 ++++++++
 tb/tb_pipeline.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and stage enumeration for the five-stage data pipeline.
package pipeline_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned NUM_STAGES    = 5;

  typedef enum logic [2:0] {
    STAGE_IF  = 3'd0,
    STAGE_ID  = 3'd1,
    STAGE_EX  = 3'd2,
    STAGE_MEM = 3'd3,
    STAGE_WB  = 3'd4
  } stage_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: WIDTH-wide register with async active-low reset and
// a synchronous clear that loads zero instead of the incoming word.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [0:WIDTH-1] d,
  output logic [0:WIDTH-1] q
);

  logic [0:WIDTH-1] data_d;
  logic [0:WIDTH-1] data_q;

  always_comb begin
    data_d = d;
    if (clr) data_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipeline.sv
// Five-stage shift pipeline (IF/ID/EX/MEM/WB) with a flush that bubbles IF and ID.
// Define PIPELINE_VALID_EN to add per-stage valid flags and the out_valid port.
module pipeline
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] data,
  input  logic             flush,
  output logic [0:WIDTH-1] out
`ifdef PIPELINE_VALID_EN
  ,
  output logic             out_valid
`endif
);

  logic [0:WIDTH-1] stage_d [NUM_STAGES];
  logic [0:WIDTH-1] stage_q [NUM_STAGES];

  logic [0:WIDTH-1] IF_data;
  logic [0:WIDTH-1] ID_data;
  logic [0:WIDTH-1] EX_data;
  logic [0:WIDTH-1] MEM_data;
  logic [0:WIDTH-1] WB_data;

  for (genvar i = 0; i < int'(NUM_STAGES); i++) begin : g_stage
    // Only the two youngest stages are killed by flush.
    localparam bit KILL = (i <= int'(STAGE_ID));

    if (i == 0) begin : g_head
      assign stage_d[i] = data;
    end else begin : g_body
      assign stage_d[i] = stage_q[i-1];
    end

    pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .clr (KILL ? flush : 1'b0),
      .d   (stage_d[i]),
      .q   (stage_q[i])
    );
  end

  assign IF_data  = stage_q[STAGE_IF];
  assign ID_data  = stage_q[STAGE_ID];
  assign EX_data  = stage_q[STAGE_EX];
  assign MEM_data = stage_q[STAGE_MEM];
  assign WB_data  = stage_q[STAGE_WB];

  assign out = WB_data;

`ifdef PIPELINE_VALID_EN
  logic [0:0] vld_d [NUM_STAGES];
  logic [0:0] vld_q [NUM_STAGES];

  // Valid flags ride alongside the data; a flush clears them exactly as it zeroes the word.
  for (genvar i = 0; i < int'(NUM_STAGES); i++) begin : g_vld
    localparam bit KILL = (i <= int'(STAGE_ID));

    if (i == 0) begin : g_head
      assign vld_d[i] = 1'b1;
    end else begin : g_body
      assign vld_d[i] = vld_q[i-1];
    end

    pipe_stage_reg #(.WIDTH(1)) u_vld (
      .clk (clk),
      .rst (rst),
      .clr (KILL ? flush : 1'b0),
      .d   (vld_d[i]),
      .q   (vld_q[i])
    );
  end

  assign out_valid = vld_q[STAGE_WB][0];
`endif

endmodule

// File: tb/tb_pipeline.sv
// Scoreboard bench for pipeline: directed steps push hand-computed expectations,
// a monitor pops and compares one entry after each rising edge.
module tb_pipeline;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic [0:W-1] data;
  logic         flush;
  logic [0:W-1] dout;
`ifdef PIPELINE_VALID_EN
  logic         dvalid;
`endif

  typedef struct {
    logic [0:W-1] out;
    logic         v;
    int           id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  pipeline #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .flush (flush),
    .out   (dout)
`ifdef PIPELINE_VALID_EN
    ,
    .out_valid (dvalid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [0:W-1] got, input logic [0:W-1] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic chk_all_clear(input string nm);
    chk({nm, ".IF"},  dut.IF_data,  '0);
    chk({nm, ".ID"},  dut.ID_data,  '0);
    chk({nm, ".EX"},  dut.EX_data,  '0);
    chk({nm, ".MEM"}, dut.MEM_data, '0);
    chk({nm, ".WB"},  dut.WB_data,  '0);
    chk({nm, ".out"}, dout,         '0);
`ifdef PIPELINE_VALID_EN
    chk({nm, ".out_valid"}, W'(dvalid), '0);
`endif
  endtask

  // Drive one edge's inputs and queue the out value expected after that edge.
  task automatic step(input logic [0:W-1] d, input logic f,
                      input logic [0:W-1] e_out, input logic e_v);
    exp_t e;
    @(negedge clk);
    rst   = 1'b1;
    data  = d;
    flush = f;
    e.out = e_out;
    e.v   = e_v;
    e.id  = step_id;
    step_id++;
    exp_q.push_back(e);
  endtask

  // Assert reset between edges, confirm immediate clear, hold through two edges.
  task automatic do_reset(input string nm);
    @(negedge clk);
    data  = 32'hFFFF_FFFF;
    flush = 1'b0;
    rst   = 1'b0;
    #1;
    chk_all_clear({nm, ".async"});
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_clear({nm, ".held"});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dout !== e.out) begin
          errors++;
          $display("FAIL out step %0d: got %h expected %h", e.id, dout, e.out);
        end
`ifdef PIPELINE_VALID_EN
        checks++;
        if (dvalid !== e.v) begin
          errors++;
          $display("FAIL out_valid step %0d: got %b expected %b", e.id, dvalid, e.v);
        end
`endif
      end
    end
  end

  initial begin : stimulus
    rst   = 1'b1;
    data  = '0;
    flush = 1'b0;

    // Reset with all-ones data driven
    do_reset("reset0");

    // Fill 1..5, then drain
    step(32'd1, 1'b0, 32'd0, 1'b0);
    step(32'd2, 1'b0, 32'd0, 1'b0);
    step(32'd3, 1'b0, 32'd0, 1'b0);
    step(32'd4, 1'b0, 32'd0, 1'b0);
    step(32'd5, 1'b0, 32'd1, 1'b1);
    step(32'd0, 1'b0, 32'd2, 1'b1);
    step(32'd0, 1'b0, 32'd3, 1'b1);
    step(32'd0, 1'b0, 32'd4, 1'b1);
    step(32'd0, 1'b0, 32'd5, 1'b1);

    // Mid-stream reset: stages hold 0,0,0,0,5 style content here
    do_reset("reset_mid");

    // Single flush at the edge sampling 7
    step(32'd1, 1'b0, 32'd0, 1'b0);
    step(32'd2, 1'b0, 32'd0, 1'b0);
    step(32'd3, 1'b0, 32'd0, 1'b0);
    step(32'd4, 1'b0, 32'd0, 1'b0);
    step(32'd5, 1'b0, 32'd1, 1'b1);
    step(32'd6, 1'b0, 32'd2, 1'b1);
    step(32'd7, 1'b1, 32'd3, 1'b1);
    step(32'd8, 1'b0, 32'd4, 1'b1);
    step(32'hA, 1'b0, 32'd5, 1'b1);
    step(32'hA, 1'b0, 32'd0, 1'b0);
    step(32'd0, 1'b0, 32'd0, 1'b0);
    step(32'd0, 1'b0, 32'd8, 1'b1);
    step(32'd0, 1'b0, 32'hA, 1'b1);
    step(32'd0, 1'b0, 32'hA, 1'b1);

    do_reset("reset2");

    // Held flush for 8 edges after filling 1..5; incoming data is discarded
    step(32'd1, 1'b0, 32'd0, 1'b0);
    step(32'd2, 1'b0, 32'd0, 1'b0);
    step(32'd3, 1'b0, 32'd0, 1'b0);
    step(32'd4, 1'b0, 32'd0, 1'b0);
    step(32'd5, 1'b0, 32'd1, 1'b1);
    step(32'hDEAD, 1'b1, 32'd2, 1'b1);
    step(32'hDEAD, 1'b1, 32'd3, 1'b1);
    step(32'hDEAD, 1'b1, 32'd4, 1'b1);
    step(32'hDEAD, 1'b1, 32'd0, 1'b0);
    step(32'hDEAD, 1'b1, 32'd0, 1'b0);
    step(32'hDEAD, 1'b1, 32'd0, 1'b0);
    step(32'hDEAD, 1'b1, 32'd0, 1'b0);
    step(32'hDEAD, 1'b1, 32'd0, 1'b0);

    do_reset("reset3");

    // Bit order: bit 0 is the MSB
    step(32'h8000_0000, 1'b0, 32'd0, 1'b0);
    step(32'd0, 1'b0, 32'd0, 1'b0);
    step(32'd0, 1'b0, 32'd0, 1'b0);
    step(32'd0, 1'b0, 32'd0, 1'b0);
    step(32'd0, 1'b0, 32'h8000_0000, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (dout[0] !== 1'b1) begin
      errors++;
      $display("FAIL msb_bit0: got %b expected 1", dout[0]);
    end

    // Let the monitor drain any remaining expectations, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
